life_event_arbiter: RTL and testbench

Serializes per-frame life-changing events (bullet hits and heart pickups for both tanks) into a single valid/ready event stream consumed by the life/heart state machine. Captures requests into sticky pending flags, arbitrates damage-over-heal with round-robin between tanks, and enforces per-tank post-hit invulnerability. Sits between the collision/pickup detectors and the game state machine, clocked on the frame clock.

---
 rtl/life_event_arbiter.sv | 148 ++++++++++++++
 tb/tb_life_event_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_event_arbiter.sv
// life_event_arbiter: serializes tank hit/heal requests onto one valid/ready stream.
// Heal path is compiled in only when HEAL_EVENTS_EN is defined.
module life_event_arbiter #(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int CW = $clog2(COOLDOWN_FRAMES + 1)
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       game_active,
  input  logic       shot_hit1,
  input  logic       shot_hit2,
  input  logic       pickup1,
  input  logic       pickup2,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_tank,
  output logic       ev_kind,
  output logic [3:0] pending,
  output logic       invuln1,
  output logic       invuln2,
  output logic [7:0] dropped_cnt
);

  localparam int CNT_W = (CW > 0) ? CW : 1;
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CD_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [1:0]       dmg;
  logic [1:0]       heal;
  logic             rr;
  logic [CNT_W-1:0] cd1;
  logic [CNT_W-1:0] cd2;

  logic       accept;
  logic       acc_dmg1;
  logic       acc_dmg2;
  logic       drop1;
  logic       drop2;
  logic [1:0] dmg_nxt;
  logic       sel_kind;
  logic       sel_tank;
  logic [1:0] pool;
  logic [8:0] drop_sum;

  assign invuln1 = |cd1;
  assign invuln2 = |cd2;
  assign pending = {heal, dmg};

  // A flush in OFFER withdraws the event; it never counts as an accept
  assign accept   = (state == OFFER) && ev_valid
                    && ev_ready && game_active;
  assign acc_dmg1 = accept && !ev_kind && !ev_tank;
  assign acc_dmg2 = accept && !ev_kind && ev_tank;

  assign drop1 = game_active && shot_hit1
                 && (invuln1 || acc_dmg1);
  assign drop2 = game_active && shot_hit2
                 && (invuln2 || acc_dmg2);

  assign dmg_nxt[0] = game_active
                      && ((dmg[0] && !acc_dmg1)
                      || (shot_hit1 && !drop1));
  assign dmg_nxt[1] = game_active
                      && ((dmg[1] && !acc_dmg2)
                      || (shot_hit2 && !drop2));

  assign drop_sum = {1'b0, dropped_cnt}
                    + 9'(drop1) + 9'(drop2);

  // Damage outranks heal; rr breaks ties between tanks
  assign sel_kind = ~|dmg;
  assign pool     = sel_kind ? heal : dmg;
  assign sel_tank = (&pool) ? rr : pool[1];

`ifdef HEAL_EVENTS_EN
  logic [1:0] heal_q;
  logic       acc_heal1;
  logic       acc_heal2;

  assign acc_heal1 = accept && ev_kind && !ev_tank;
  assign acc_heal2 = accept && ev_kind && ev_tank;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      heal_q <= 2'b00;
    end else begin
      heal_q[0] <= game_active
                   && ((heal_q[0] && !acc_heal1) || pickup1);
      heal_q[1] <= game_active
                   && ((heal_q[1] && !acc_heal2) || pickup2);
    end
  end

  assign heal = heal_q;
`else
  logic unused_pickups;
  assign unused_pickups = pickup1 | pickup2;
  assign heal = 2'b00;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      dmg         <= 2'b00;
      rr          <= 1'b0;
      cd1         <= '0;
      cd2         <= '0;
      ev_valid    <= 1'b0;
      ev_tank     <= 1'b0;
      ev_kind     <= 1'b0;
      dropped_cnt <= 8'd0;
    end else begin
      dmg         <= dmg_nxt;
      dropped_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (acc_dmg1)     cd1 <= CD_LOAD;
      else if (invuln1) cd1 <= cd1 - CD_ONE;

      if (acc_dmg2)     cd2 <= CD_LOAD;
      else if (invuln2) cd2 <= cd2 - CD_ONE;

      unique case (state)
        IDLE: begin
          if (game_active && (|pending)) begin
            state    <= OFFER;
            ev_valid <= 1'b1;
            ev_tank  <= sel_tank;
            ev_kind  <= sel_kind;
          end
        end
        OFFER: begin
          if (!game_active) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
          end else if (ev_ready) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            rr       <= ~ev_tank;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_event_arbiter.sv
// tb_life_event_arbiter: vector table, directed corner sequences and a
// random run against a frame-level model of the arbiter.
module tb_life_event_arbiter;

  localparam int CD = 30;
`ifdef HEAL_EVENTS_EN
  localparam bit HEAL = 1'b1;
`else
  localparam bit HEAL = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       game_active = 1'b0;
  logic       shot_hit1 = 1'b0;
  logic       shot_hit2 = 1'b0;
  logic       pickup1 = 1'b0;
  logic       pickup2 = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic       ev_tank;
  logic       ev_kind;
  logic [3:0] pending;
  logic       invuln1;
  logic       invuln2;
  logic [7:0] dropped_cnt;

  int errors = 0;
  int checks = 0;

  // model state
  bit [3:0] m_pend;
  int       m_cd[2];
  bit       m_rr;
  bit       m_valid;
  bit       m_tank;
  bit       m_kind;
  int       m_drop;

  life_event_arbiter #(.COOLDOWN_FRAMES(CD)) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .game_active(game_active),
    .shot_hit1(shot_hit1),
    .shot_hit2(shot_hit2),
    .pickup1(pickup1),
    .pickup2(pickup2),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_tank(ev_tank),
    .ev_kind(ev_kind),
    .pending(pending),
    .invuln1(invuln1),
    .invuln2(invuln2),
    .dropped_cnt(dropped_cnt)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    bit       ga, h1, h2, rdy;
    bit       v, t;
    bit [1:0] pd;
    bit       i1, i2;
    int       drop;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {ev_valid, ev_tank, ev_kind, pending,
            invuln1, invuln2, dropped_cnt};
  endfunction

  function automatic logic [16:0] model_outs();
    return {m_valid, m_tank, m_kind, m_pend,
            m_cd[0] > 0, m_cd[1] > 0, 8'(m_drop)};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_cd[0] = 0; m_cd[1] = 0;
    m_rr = 0; m_valid = 0; m_tank = 0; m_kind = 0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit ga, h1, h2, p1, p2, rdy);
    bit [3:0] np;
    bit [1:0] pool;
    bit       hit[2];
    bit       pk[2];
    bit       acc, nv, nt, nk, nrr;
    int       drops;
    hit[0] = h1; hit[1] = h2;
    pk[0] = p1; pk[1] = p2;
    np = m_pend; drops = 0;
    acc = ga && m_valid && rdy;
    nv = m_valid; nt = m_tank; nk = m_kind; nrr = m_rr;
    if (!ga) begin
      np = '0;
      nv = 0;
    end else begin
      if (acc) begin
        np[{m_kind, m_tank}] = 1'b0;
        nv = 0;
        nrr = !m_tank;
      end else if (!m_valid && m_pend != 0) begin
        nv = 1;
        if (m_pend[1:0] != 0) begin
          nk = 0; pool = m_pend[1:0];
        end else begin
          nk = 1; pool = m_pend[3:2];
        end
        nt = (pool == 2'b11) ? m_rr : (pool == 2'b10);
      end
      for (int t = 0; t < 2; t++) begin
        if (hit[t]) begin
          if (m_cd[t] > 0 || (acc && !m_kind && m_tank == t))
            drops++;
          else
            np[t] = 1'b1;
        end
        if (HEAL && pk[t]) np[2+t] = 1'b1;
      end
    end
    for (int t = 0; t < 2; t++) begin
      if (acc && !m_kind && m_tank == t) m_cd[t] = CD;
      else if (m_cd[t] > 0) m_cd[t]--;
    end
    m_pend = np; m_valid = nv; m_tank = nt;
    m_kind = nk; m_rr = nrr;
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  task automatic step(input bit ga, h1, h2, p1, p2, rdy);
    game_active = ga; shot_hit1 = h1; shot_hit2 = h2;
    pickup1 = p1; pickup2 = p2; ev_ready = rdy;
    @(posedge frame_clk);
    model_step(ga, h1, h2, p1, p2, rdy);
    #1;
    chk("model", 32'(outs()), 32'(model_outs()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    game_active = 0; shot_hit1 = 0; shot_hit2 = 0;
    pickup1 = 0; pickup2 = 0; ev_ready = 0;
    Reset = 1;
    #1;
    chk("reset_async", 32'(outs()), 32'd0);
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset = 0;
  endtask

  task automatic run_pair(input string nm, input bit exp_first);
    bit tk[2];
    int cy[2];
    int n;
    n = 0; tk[0] = 0; tk[1] = 0; cy[0] = 0; cy[1] = 0;
    step(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0, 1);
      if (ev_valid === 1'b1) begin
        if (n < 2) begin
          tk[n] = ev_tank; cy[n] = i;
        end
        n++;
      end
    end
    chk({nm, "_count"}, n, 2);
    chk({nm, "_first"}, 32'(tk[0]), 32'(exp_first));
    chk({nm, "_second"}, 32'(tk[1]), 32'(!exp_first));
    chk({nm, "_gap"}, cy[1] - cy[0], 2);
  endtask

  initial begin
    vec_t tbl[8];
    int   n;
    bit   found;

    tbl[0] = '{1,1,0,1, 0,0,2'b01,0,0,0};
    tbl[1] = '{1,0,0,1, 1,0,2'b01,0,0,0};
    tbl[2] = '{1,0,0,1, 0,0,2'b00,1,0,0};
    tbl[3] = '{1,1,1,1, 0,0,2'b10,1,0,1};
    tbl[4] = '{1,0,0,1, 1,1,2'b10,1,0,1};
    tbl[5] = '{1,0,0,1, 0,1,2'b00,1,1,1};
    tbl[6] = '{1,1,1,1, 0,1,2'b00,1,1,3};
    tbl[7] = '{0,1,0,1, 0,1,2'b00,1,1,3};

    #2;
    do_reset();

    // vector table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].ga, tbl[i].h1, tbl[i].h2, 0, 0, tbl[i].rdy);
      chk($sformatf("vec%0d", i),
          {ev_valid, ev_tank, pending[1:0], invuln1, invuln2,
           dropped_cnt},
          {tbl[i].v, tbl[i].t, tbl[i].pd, tbl[i].i1, tbl[i].i2,
           8'(tbl[i].drop)});
    end

    // single hit, latency and invulnerability length
    do_reset();
    step(1, 1, 0, 0, 0, 1);
    chk("single_lat1", 32'(ev_valid), 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("single_ev", {ev_valid, ev_tank, ev_kind}, 3'b100);
    step(1, 0, 0, 0, 0, 1);
    chk("single_acc", {ev_valid, invuln1}, 2'b01);
    n = 0;
    for (int i = 0; i < 40 && invuln1 === 1'b1; i++) begin
      n++;
      step(1, 0, 0, 0, 0, 1);
    end
    chk("invuln_len", n, CD);

    // round robin between simultaneous hits
    do_reset();
    run_pair("pair_a", 1'b0);
    idle(35);
    run_pair("pair_b", 1'b0);
    idle(35);
    step(1, 1, 0, 0, 0, 1);
    idle(2);
    idle(35);
    run_pair("pair_rr", 1'b1);

    // invulnerability window boundaries
    do_reset();
    step(1, 1, 0, 0, 0, 1);
    idle(2);
    idle(9);
    step(1, 1, 0, 0, 0, 1);
    chk("inv_drop10", {pending[0], dropped_cnt}, 9'd1);
    idle(19);
    step(1, 1, 0, 0, 0, 1);
    chk("inv_drop30", {pending[0], dropped_cnt}, 9'd2);
    step(1, 1, 0, 0, 0, 1);
    chk("inv_take31", {pending[0], dropped_cnt}, 9'h102);
    step(1, 0, 0, 0, 0, 0);
    chk("inv_ev31", {ev_valid, ev_tank}, 2'b10);

    // flush while offering
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("flush_offer", {ev_valid, ev_tank}, 2'b11);
    step(0, 1, 1, 0, 0, 1);
    chk("flush", {ev_valid, pending, dropped_cnt}, 13'd0);

`ifdef HEAL_EVENTS_EN
    // damage beats heal, held under backpressure
    do_reset();
    step(1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("prio_hold", {ev_valid, ev_tank, ev_kind}, 3'b100);
    end
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("prio_heal", {ev_valid, ev_tank, ev_kind}, 3'b111);
`else
    do_reset();
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 1);
    chk("no_heal", {ev_valid, pending}, 5'd0);
`endif

    // saturation, then reset mid-offer
    do_reset();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1, 1, 1, 0, 0, 1);
      found = (dropped_cnt == 8'hFF);
    end
    chk("sat_reach", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 1);
    chk("sat_hold", 32'(dropped_cnt), 32'hFF);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1, 1, 1, 0, 0, 0);
      found = (ev_valid === 1'b1);
    end
    chk("offer_before_rst", 32'(found), 32'd1);
    do_reset();

    // random run against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
